data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 150 +++++++++++++++
 tb/tb_data_memory_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Word-addressed data-memory responder: byte-masked writes, full-word reads, WAIT_CYCLES wait states, one-cycle ready pulse.
// Optional `DMEM_MMIO_EN adds a free-running cycle counter mapped at MMIO_ADDR.
module data_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr_out,
  input  logic [31:0] data_out,
  input  logic [3:0]  MemWriteEnable,
  output logic [31:0] data_in,
  output logic        ready,
  output logic        err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_wait_cnt;
  logic [29:0]      r_word;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_data_in;
  logic             r_ready;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_access;
  logic             w_is_write;
  logic             w_in_range;
  logic             w_mmio_hit;
  logic             w_mem_hit;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_mmio_rd;
  logic [31:0]      w_rd_data;
  logic             w_unused;

  // Byte offset is meaningless for a word array; MMIO_ADDR is only decoded in the MMIO build.
  assign w_unused   = ^{addr_out[1:0], MMIO_ADDR};

  assign w_access   = (r_state == S_ACCESS);
  assign w_is_write = |r_be;
  assign w_in_range = ({2'b00, r_word} < 32'(DEPTH_WORDS));
  assign w_idx      = r_word[IDX_W-1:0];
  assign w_mem_hit  = w_in_range && !w_mmio_hit;

`ifdef DMEM_MMIO_EN
  logic [31:0] r_cycle_cnt;

  assign w_mmio_hit = (r_word == MMIO_ADDR[31:2]);
  // A read returns the count as it stands in the ready cycle, i.e. the value this edge produces.
  assign w_mmio_rd  = r_cycle_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= 32'd0;
    end else if (w_access && w_is_write && w_mmio_hit) begin
      r_cycle_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end
`else
  assign w_mmio_hit = 1'b0;
  assign w_mmio_rd  = 32'd0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_rd_data = 32'd0;
    if (w_mmio_hit) begin
      w_rd_data = w_mmio_rd;
    end else if (w_in_range) begin
      w_rd_data = r_mem[w_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_word     <= 30'd0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_data_in  <= 32'd0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_word  <= addr_out[31:2];
            r_wdata <= data_out;
            r_be    <= MemWriteEnable;
            if (WAIT_CYCLES > 0) begin
              r_state    <= S_WAIT;
              r_wait_cnt <= WAIT_LOAD;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= S_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          r_ready <= 1'b1;
          r_err   <= !w_in_range && !w_mmio_hit;
          // Write completions leave the last read word on data_in.
          if (!w_is_write) begin
            r_data_in <= w_rd_data;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; it only guards against writing while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && w_access && w_is_write && w_mem_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_in = r_data_in;
  assign ready   = r_ready;
  assign err     = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases plus random traffic against a
// transaction-level model (sparse byte-valid memory, completion queue keyed by cycle number).
module tb_data_memory_responder;

  localparam int          DEPTH = 1024;
  localparam int          W     = 1;
  localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [3:0]  MemWriteEnable;
  logic [31:0] data_in;
  logic        ready;
  logic        err;

  data_memory_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W),
    .MMIO_ADDR  (MMIO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .addr_out      (addr_out),
    .data_out      (data_out),
    .MemWriteEnable(MemWriteEnable),
    .data_in       (data_in),
    .ready         (ready),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    bit          rd;
    logic        err;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_data [int unsigned];
  logic [3:0]  m_val  [int unsigned];
  int unsigned cyc     = 0;
  int unsigned next_ok = 0;
  int unsigned mclr    = 0;
  logic [31:0] hold      = 32'h0;
  logic [31:0] hold_mask = 32'hFFFF_FFFF;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv,
                       input logic [31:0] mask);
    n_cmp++;
    if (((act ^ expv) & mask) !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mask %h) at cycle %0d", name, act, expv, mask, cyc);
    end
  endtask

  // Edge counter; a reset edge empties the model's in-flight state.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      exp_q.delete();
      hold      = 32'h0;
      hold_mask = 32'hFFFF_FFFF;
      next_ok   = cyc;
      mclr      = cyc;
    end
  end

  // Every cycle: either a completion is due (ready/err/data) or outputs must be quiet and held.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.rd) begin
          hold      = e.data;
          hold_mask = e.mask;
        end
        check("ready_pulse", {31'b0, ready}, 32'd1, 32'd1);
        check("err_on_ready", {31'b0, err}, {31'b0, e.err}, 32'd1);
        check("data_on_ready", data_in, hold, hold_mask);
      end else begin
        check("ready_quiet", {31'b0, ready}, 32'd0, 32'd1);
        check("err_quiet", {31'b0, err}, 32'd0, 32'd1);
        check("data_held", data_in, hold, hold_mask);
      end
    end
  end

  task automatic model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input int unsigned accept);
    exp_t        e;
    int unsigned w;
    bit          mmio;
    logic [31:0] word;
    logic [3:0]  val;
    w      = a[31:2];
    e.due  = accept + W + 1;
    e.rd   = (be == 4'b0000);
    e.err  = 1'b0;
    e.data = 32'h0;
    e.mask = 32'hFFFF_FFFF;
`ifdef DMEM_MMIO_EN
    mmio = (a[31:2] == MMIO[31:2]);
`else
    mmio = 1'b0;
`endif
    if (mmio) begin
      if (e.rd) e.data = e.due - mclr;
      else      mclr   = e.due;
    end else if (w < DEPTH) begin
      word = m_data.exists(w) ? m_data[w] : 32'h0;
      val  = m_val.exists(w)  ? m_val[w]  : 4'h0;
      if (e.rd) begin
        e.data = word;
        for (int i = 0; i < 4; i++) e.mask[8*i +: 8] = {8{val[i]}};
      end else begin
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
        m_data[w] = word;
        m_val[w]  = val | be;
      end
    end else begin
      e.err = 1'b1;
    end
    exp_q.push_back(e);
    next_ok = e.due;
  endtask

  // Issues one transaction once the DUT is idle; optionally drives junk while it is busy.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input bit junk, output logic [31:0] rdata, output logic rerr,
                     output int lat);
    int unsigned accept;
    while (cyc < next_ok) @(negedge clk);
    accept = cyc + 1;
    model_apply(a, d, be, accept);
    addr_out       = a;
    data_out       = d;
    MemWriteEnable = be;
    req            = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cyc >= next_ok) break;
      if (junk) begin
        req            = 1'($urandom_range(0, 1));
        addr_out       = $urandom;
        data_out       = $urandom;
        MemWriteEnable = 4'($urandom);
      end else begin
        req = 1'b0;
      end
    end
    req   = 1'b0;
    rdata = data_in;
    rerr  = err;
    lat   = int'(cyc - accept);
  endtask

  logic [31:0] rd;
  logic        re;
  int          lat;
  logic [31:0] ra;
  logic [3:0]  rbe;

  initial begin
    rst = 1'b1; req = 1'b0; addr_out = 32'h0; data_out = 32'h0; MemWriteEnable = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, ready}, 32'd0, 32'd1);
      check("idle_err", {31'b0, err}, 32'd0, 32'd1);
      check("idle_data", data_in, 32'h0, 32'hFFFF_FFFF);
    end

    txn(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, rd, re, lat);
    check("wr_latency", lat, 32'd2, 32'hFFFF_FFFF);
    txn(32'h10, 32'h0, 4'b0000, 1'b0, rd, re, lat);
    check("rd_10_data", rd, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    check("rd_10_err", {31'b0, re}, 32'd0, 32'd1);

    txn(32'h20, 32'h1122_3344, 4'b1111, 1'b0, rd, re, lat);
    txn(32'h20, 32'hAAAA_AAAA, 4'b0100, 1'b0, rd, re, lat);
    txn(32'h20, 32'h5555_5555, 4'b0011, 1'b0, rd, re, lat);
    txn(32'h20, 32'h0, 4'b0000, 1'b0, rd, re, lat);
    check("merge_20", rd, 32'h11AA_5555, 32'hFFFF_FFFF);

    txn(32'h0FFC, 32'h1234_5678, 4'b1111, 1'b0, rd, re, lat);
    txn(32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b0, rd, re, lat);
    check("oor_wr_err", {31'b0, re}, 32'd1, 32'd1);
    txn(32'h1000, 32'h0, 4'b0000, 1'b0, rd, re, lat);
    check("oor_rd_err", {31'b0, re}, 32'd1, 32'd1);
    check("oor_rd_data", rd, 32'h0, 32'hFFFF_FFFF);
    txn(32'h0FFC, 32'h0, 4'b0000, 1'b0, rd, re, lat);
    check("last_word_kept", rd, 32'h1234_5678, 32'hFFFF_FFFF);

    // Reset lands while the zero write to 0x10 sits in WAIT.
    while (cyc < next_ok) @(negedge clk);
    addr_out = 32'h10; data_out = 32'h0; MemWriteEnable = 4'b1111; req = 1'b1;
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_drop_ready", {31'b0, ready}, 32'd0, 32'd1);
    end
    rst = 1'b1; req = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_req_ignored", {31'b0, ready}, 32'd0, 32'd1);
    end
    txn(32'h10, 32'h0, 4'b0000, 1'b0, rd, re, lat);
    check("rst_write_dropped", rd, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    txn(MMIO, 32'h7777_7777, 4'b1111, 1'b0, rd, re, lat);
    txn(MMIO, 32'h0, 4'b0000, 1'b0, rd, re, lat);
`ifdef DMEM_MMIO_EN
    check("mmio_rd_data", rd, 32'd3, 32'hFFFF_FFFF);
    check("mmio_rd_err", {31'b0, re}, 32'd0, 32'd1);
`else
    check("mmio_rd_data", rd, 32'h0, 32'hFFFF_FFFF);
    check("mmio_rd_err", {31'b0, re}, 32'd1, 32'd1);
`endif

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    ra = (32'($urandom_range(0, 7)) << 2);
        2:       ra = (32'($urandom_range(1016, 1023)) << 2);
        3:       ra = (32'($urandom_range(1024, 1031)) << 2);
        4:       ra = $urandom;
        default: ra = MMIO;
      endcase
      ra  = ra | 32'($urandom_range(0, 3));
      rbe = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom_range(1, 15));
      txn(ra, $urandom, rbe, 1'b1, rd, re, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
